// File: rtl/lc3_pipe_sequencer_if.sv
// rtl/lc3_pipe_sequencer_if.sv - fetch/memory and stage-enable bundle for lc3_pipe_sequencer
// Ports: IR, psr, complete_instr, complete_data into the sequencer;
//        enable_*, mem_state, br_taken, stall_pipe, mem_timeout, retired_count out of it.
interface lc3_pipe_sequencer_if #(
    parameter int CNT_W = 16
);
    logic [15:0]      IR;
    logic [2:0]       psr;
    logic             complete_instr;
    logic             complete_data;
    logic             enable_fetch;
    logic             enable_decode;
    logic             enable_execute;
    logic             enable_writeback;
    logic             enable_updatePC;
    logic [1:0]       mem_state;
    logic             br_taken;
    logic             stall_pipe;
    logic             mem_timeout;
    logic [CNT_W-1:0] retired_count;

    // Environment side: supplies instruction, flags and handshake completions.
    modport master (
        output IR, psr, complete_instr, complete_data,
        input  enable_fetch, enable_decode, enable_execute, enable_writeback,
        input  enable_updatePC, mem_state, br_taken, stall_pipe, mem_timeout,
        input  retired_count
    );

    // Sequencer side.
    modport slave (
        input  IR, psr, complete_instr, complete_data,
        output enable_fetch, enable_decode, enable_execute, enable_writeback,
        output enable_updatePC, mem_state, br_taken, stall_pipe, mem_timeout,
        output retired_count
    );
endinterface

// File: rtl/lc3_pipe_sequencer.sv
// rtl/lc3_pipe_sequencer.sv - LC-3 instruction sequencer FSM with memory phases, timeout halt and retire counter
// Ports: clock (rising edge), reset (async, active-low), bus (lc3_pipe_sequencer_if.slave).
// Params: MAX_WAIT cycles per wait phase before halt, EN_TIMEOUT enables halt, CNT_W retire counter width.
module lc3_pipe_sequencer #(
    parameter int MAX_WAIT   = 15,
    parameter int EN_TIMEOUT = 1,
    parameter int CNT_W      = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    lc3_pipe_sequencer_if.slave  bus
);
    // Counter only needs to reach MAX_WAIT-1: that value marks the last allowed wait cycle.
    localparam int WW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);
    localparam logic [WW-1:0] WLAST = WW'(MAX_WAIT - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM_IND,
        S_MEM_RD, S_MEM_WR, S_WB, S_UPDPC, S_HALT
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WW-1:0]    r_wait;
    logic [CNT_W-1:0] r_retired;

    logic       w_mem_op, w_write, w_indirect, w_reg_write, w_branch, w_jump;
    logic       w_in_mem, w_in_wait, w_complete, w_expire;
    logic [4:0] w_en;
    logic [1:0] w_mem_state;

    assign w_mem_op    = bus.IR[13] & (bus.IR[15:14] != 2'b11);
    assign w_write     = bus.IR[12];
    assign w_indirect  = (bus.IR[15:14] == 2'b10);
    assign w_reg_write = (bus.IR[15:12] == 4'b0001) | (bus.IR[15:12] == 4'b0101) |
                         (bus.IR[15:12] == 4'b1001) | (bus.IR[15:12] == 4'b1110) |
                         (bus.IR[15:12] == 4'b0010) | (bus.IR[15:12] == 4'b0110) |
                         (bus.IR[15:12] == 4'b1010);
    assign w_branch    = (bus.IR[15:12] == 4'b0000);
    assign w_jump      = (bus.IR[15:12] == 4'b1100);

    assign w_in_mem   = (r_state == S_MEM_IND) | (r_state == S_MEM_RD) | (r_state == S_MEM_WR);
    assign w_in_wait  = w_in_mem | (r_state == S_FETCH);
    // Each wait phase listens only to its own completion strobe.
    assign w_complete = (r_state == S_FETCH) ? bus.complete_instr : bus.complete_data;
    // Checked only after the complete input, so a late completion still wins.
    assign w_expire   = (EN_TIMEOUT != 0) && (r_wait == WLAST);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_wait    <= '0;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            // Any entry into a wait phase (including MEM->MEM) restarts the count.
            if ((w_next == S_FETCH || w_next == S_MEM_IND || w_next == S_MEM_RD ||
                 w_next == S_MEM_WR) && (w_next != r_state)) begin
                r_wait <= '0;
            end else if (w_in_wait && !w_complete && (r_wait != WLAST)) begin
                r_wait <= r_wait + 1'b1;
            end
            if (r_state == S_UPDPC) begin
                r_retired <= r_retired + 1'b1;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:   w_next = S_FETCH;
            S_FETCH: begin
                if (bus.complete_instr) w_next = S_DECODE;
                else if (w_expire)      w_next = S_HALT;
            end
            S_DECODE: w_next = S_EXEC;
            S_EXEC: begin
                if (!w_mem_op)       w_next = S_WB;
                else if (w_indirect) w_next = S_MEM_IND;
                else if (w_write)    w_next = S_MEM_WR;
                else                 w_next = S_MEM_RD;
            end
            S_MEM_IND: begin
                if (bus.complete_data) w_next = w_write ? S_MEM_WR : S_MEM_RD;
                else if (w_expire)     w_next = S_HALT;
            end
            S_MEM_RD, S_MEM_WR: begin
                if (bus.complete_data) w_next = S_WB;
                else if (w_expire)     w_next = S_HALT;
            end
            S_WB:     w_next = S_UPDPC;
            S_UPDPC:  w_next = S_FETCH;
            S_HALT:   w_next = S_HALT;
            default:  w_next = S_IDLE;
        endcase
    end

    // Enables ordered {fetch, decode, execute, writeback, updatePC}.
    always_comb begin
        w_en        = 5'b00000;
        w_mem_state = 2'd3;
        unique case (r_state)
            S_FETCH:   w_en = 5'b10000;
            S_DECODE:  w_en = 5'b01000;
            S_EXEC:    w_en = 5'b00100;
            S_MEM_IND: w_mem_state = 2'd1;
            S_MEM_RD:  w_mem_state = 2'd0;
            S_MEM_WR:  w_mem_state = 2'd2;
            S_WB:      w_en = {3'b000, w_reg_write, 1'b0};
            S_UPDPC:   w_en = 5'b00001;
            default:   w_en = 5'b00000;
        endcase
    end

    assign bus.enable_fetch     = w_en[4];
    assign bus.enable_decode    = w_en[3];
    assign bus.enable_execute   = w_en[2];
    assign bus.enable_writeback = w_en[1];
    assign bus.enable_updatePC  = w_en[0];
    assign bus.mem_state        = w_mem_state;
    assign bus.br_taken         = w_en[0] & (w_jump | (w_branch & |(bus.IR[11:9] & bus.psr)));
    assign bus.stall_pipe       = w_in_mem & ~bus.complete_data;
    assign bus.mem_timeout      = (r_state == S_HALT);
    assign bus.retired_count    = r_retired;
endmodule

// File: doc/lc3_pipe_sequencer.md
# lc3_pipe_sequencer

Parametrised successor to the LC-3 pipeline controller. One FSM sequences fetch, decode, execute, memory, writeback and PC update for each instruction in IR, and drives the matching stage enables. It adds:
- separate indirect/read/write memory phases,
- per-opcode writeback gating,
- branch and jump resolution taken from IR[11:9],
- a programmable handshake timeout with a sticky halt,
- a retired-instruction counter.

It sits between the fetch/memory interface and the datapath stage registers.

## Interface
- MAX_WAIT, 15: cycles allowed in any wait phase (fetch or memory) before timeout; must be ≥1.
- EN_TIMEOUT, 1: 1 enables the timeout/halt logic; 0 means wait forever.
- CNT_W, 16: width of retired_count.
- clock  in  1  single clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low (0 = reset).
- IR  in  16  instruction register; stable from DECODE through UPDPC.
- psr  in  3  condition codes {N,Z,P}.
- complete_instr  in  1  instruction fetch done; sampled in FETCH.
- complete_data  in  1  data access done; sampled in MEM phases.
- enable_fetch, enable_decode, enable_execute, enable_writeback, enable_updatePC  out  1 each  stage enables.
- mem_state  out  2  0 = read, 1 = indirect pointer read, 2 = write, 3 = idle.
- br_taken  out  1  redirect PC; valid only with enable_updatePC.
- stall_pipe  out  1  a memory phase is waiting on complete_data.
- mem_timeout  out  1  sticky; set when the FSM enters HALT.
- retired_count  out  CNT_W  number of instructions completed; wraps.

## Operation
- Opcode classes, decoded from IR[15:12]:
  - mem_op = IR[13] & (IR[15:14] != 2'b11), i.e. LD, ST, LDR, STR, LDI, STI.
  - Within a mem_op: write = IR[12]; indirect = (IR[15:14] == 2'b10).
  - reg_write = ADD 0001, AND 0101, NOT 1001, LEA 1110, LD 0010, LDR 0110, LDI 1010.
  - branch = 0000; jump = 1100.
- States:
  - IDLE: all enables 0; always goes to FETCH.
  - FETCH: enable_fetch=1. complete_instr=1 → DECODE; otherwise stay.
  - DECODE: enable_decode=1 → EXEC.
  - EXEC: enable_execute=1. mem_op → MEM_IND if indirect, else MEM_RD or MEM_WR; otherwise → WB.
  - MEM_IND: mem_state=1. complete_data=1 → MEM_WR if write, else MEM_RD.
  - MEM_RD: mem_state=0. complete_data=1 → WB.
  - MEM_WR: mem_state=2. complete_data=1 → WB.
  - WB: enable_writeback = reg_write → UPDPC.
  - UPDPC: enable_updatePC=1; retired_count increments by 1 (modulo 2^CNT_W) → FETCH.
  - HALT: all enables 0, mem_state=3, mem_timeout=1. Exited only by reset.
- mem_state=3 in every state other than the three MEM phases.
- br_taken = enable_updatePC & (jump | (branch & |(IR[11:9] & psr))). For BR with nzp=000, br_taken stays 0.
- stall_pipe = (MEM_IND | MEM_RD | MEM_WR) & !complete_data.
- Wait counter:
  - Cleared on entry to FETCH and to each MEM phase, including a MEM→MEM transition.
  - Increments every cycle the phase's complete input is low.
  - If EN_TIMEOUT=1 and complete is still low in the MAX_WAIT-th cycle of the phase, the next state is HALT.
  - A complete pulse arriving in that MAX_WAIT-th cycle is accepted and normal sequencing continues.
- complete_instr outside FETCH and complete_data outside MEM phases are ignored.

## Timing
- Reset asserted: state=IDLE, every enable=0, br_taken=0, stall_pipe=0, mem_state=3, mem_timeout=0, retired_count=0, wait counter=0.
- Reset asserted at any point, including mid-MEM or HALT, forces these values immediately, without waiting for a clock edge.
- First rising edge after reset release: IDLE → FETCH.
- Outputs are Moore (decoded from registered state), except stall_pipe and br_taken, which also depend on the current inputs.
- Latency, with complete_* asserted in the first cycle of each wait phase:
  - Non-memory instruction: 5 cycles, FETCH to UPDPC inclusive.
  - LD/LDR/ST/STR: 6 cycles.
  - LDI/STI: 7 cycles.
  - Each wait cycle without complete adds 1 cycle.
- Back-to-back instructions: FETCH immediately follows UPDPC; there are no bubbles.

## Test plan
- Reset release, IR=ADD (0x1261), complete_instr high → enables one-hot in order fetch, decode, execute, writeback, updatePC over cycles 1-5; retired_count=1; mem_state=3 throughout.
- IR=LDI (0xA405): complete_data low 2 cycles in MEM_IND, then 1-cycle pulse; then low 1 cycle in MEM_RD, then high → mem_state sequence 1,1,1,0,0; stall_pipe high in exactly 3 cycles; enable_writeback=1.
- IR=STI (0xB405) → mem_state 1 then 2; enable_writeback=0 in WB; retired_count increments.
- IR=BRz (0x0403): psr=010 → br_taken=1 only in the UPDPC cycle. Same IR with psr=100 → br_taken=0. IR=JMP (0xC1C0) → br_taken=1.
- MAX_WAIT=4, complete_instr held low → HALT entered after 4 FETCH cycles; mem_timeout=1, all enables 0, stays halted. complete_instr arriving in cycle 4 instead → DECODE follows, no timeout.
- Reset pulled low mid-MEM_RD (between clock edges) → all outputs reach reset values immediately; after release, sequencing restarts from IDLE with retired_count=0.
